matmul_job_arbiter: RTL and testbench

Shares one `systolic_matrix_multiplier` instance between `NUM_REQ` requesters. Round-robin arbitration decides which requester goes next. The block latches the winner's operands, sequences the multiplier's start/done handshake, and guards each job with a watchdog timeout. It returns the result, or an error, on a single valid/ready response channel tagged with the requester id. It sits between the job sources and the multiplier; at most one job is outstanding at a time.

---
 rtl/matmul_pkg.sv | 30 +++
 rtl/rr_grant.sv | 30 +++
 rtl/matmul_job_arbiter.sv | 159 +++++++++++++++
 tb/tb_matmul_job_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants for the matmul job arbiter: FSM encoding, default
// multiplier geometry and helpers that derive the vector/counter widths.
package matmul_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_LAUNCH = 2'd1;
   localparam state_t ST_BUSY   = 2'd2;
   localparam state_t ST_RESP   = 2'd3;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_M          = 8;
   localparam int DEF_N          = 8;
   localparam int DEF_P          = 8;

   function automatic int vec_width(input int rows, input int cols, input int dw);
      return rows * cols * dw;
   endfunction

   // A single requester still needs a 1-bit id field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int wd_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin picker: grants the first set request at or after ptr_i,
// scanning upward with wrap-around.
module rr_grant #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             any_o
);

   always_comb begin
      int idx;
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      idx         = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(ptr_i) + i) % N_REQ;
         if (!any_o && req_i[idx]) begin
            any_o        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/matmul_job_arbiter.sv
// Shares one matrix multiplier between NUM_REQ requesters: round-robin
// grant, start/done sequencing with a watchdog, tagged response channel.
module matmul_job_arbiter
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int M              = DEF_M,
   parameter int N              = DEF_N,
   parameter int P              = DEF_P,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int A_W  = vec_width(M, N, DATA_WIDTH),
   localparam int B_W  = vec_width(N, P, DATA_WIDTH),
   localparam int C_W  = vec_width(M, P, DATA_WIDTH),
   localparam int ID_W = id_width(NUM_REQ),
   localparam int WD_W = wd_width(TIMEOUT_CYCLES)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_valid_i,
   output logic [NUM_REQ-1:0]     req_ready_o,
   input  logic [NUM_REQ*A_W-1:0] req_a_i,
   input  logic [NUM_REQ*B_W-1:0] req_b_i,
   output logic                   mm_start_o,
   output logic [A_W-1:0]         mm_a_o,
   output logic [B_W-1:0]         mm_b_o,
   input  logic                   mm_done_i,
   input  logic [C_W-1:0]         mm_result_i,
   output logic                   rsp_valid_o,
   input  logic                   rsp_ready_i,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic [C_W-1:0]         rsp_result_o,
   output logic                   rsp_err_o,
   output logic                   busy_o
);

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [A_W-1:0]      mm_a_q, mm_a_d;
   logic [B_W-1:0]      mm_b_q, mm_b_d;
   logic [C_W-1:0]      rsp_result_q, rsp_result_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                mm_start_q, mm_start_d;
   logic                busy_q, busy_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     win_idx;
   logic                any_req;

   rr_grant #(
      .N_REQ (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr_grant (
      .req_i       (req_valid_i),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (win_idx),
      .any_o       (any_req)
   );

   // Grants are only offered while idle; nothing is accepted in RESP.
   assign req_ready_o = (state_q == ST_IDLE) ? grant : '0;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      rsp_id_d     = rsp_id_q;
      wd_d         = wd_q;
      mm_a_d       = mm_a_q;
      mm_b_d       = mm_b_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      rsp_valid_d  = rsp_valid_q;
      mm_start_d   = 1'b0;
      busy_d       = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               mm_a_d     = req_a_i[int'(win_idx)*A_W +: A_W];
               mm_b_d     = req_b_i[int'(win_idx)*B_W +: B_W];
               rsp_id_d   = win_idx;
               rr_ptr_d   = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
               mm_start_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wd_d    = '0;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            // done is checked first so it wins over a coincident timeout
            if (mm_done_i) begin
               rsp_result_d = mm_result_i;
               rsp_err_d    = 1'b0;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES-1)) begin
               rsp_result_d = '0;
               rsp_err_d    = 1'b1;
               rsp_valid_d  = 1'b1;
               state_d      = ST_RESP;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               busy_d      = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         rsp_id_q     <= '0;
         wd_q         <= '0;
         mm_a_q       <= '0;
         mm_b_q       <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
         rsp_valid_q  <= 1'b0;
         mm_start_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         rsp_id_q     <= rsp_id_d;
         wd_q         <= wd_d;
         mm_a_q       <= mm_a_d;
         mm_b_q       <= mm_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
         rsp_valid_q  <= rsp_valid_d;
         mm_start_q   <= mm_start_d;
         busy_q       <= busy_d;
      end
   end

   assign mm_start_o   = mm_start_q;
   assign mm_a_o       = mm_a_q;
   assign mm_b_o       = mm_b_q;
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_id_o     = rsp_id_q;
   assign rsp_result_o = rsp_result_q;
   assign rsp_err_o    = rsp_err_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_matmul_job_arbiter.sv
// Bench for matmul_job_arbiter: stub multiplier with programmable latency,
// round-robin/timing reference model, directed plus randomized jobs.
module tb_matmul_job_arbiter;

   localparam int DW = 8, M = 8, N = 8, P = 8, NR = 4, TO = 600;
   localparam int AW = M*N*DW, BW = N*P*DW, RW = M*P*DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [NR*AW-1:0]  req_a = '0;
   logic [NR*BW-1:0]  req_b = '0;
   logic              mm_start, mm_done;
   logic              done_x = 1'b0;
   logic [AW-1:0]     mm_a;
   logic [BW-1:0]     mm_b;
   logic [RW-1:0]     mm_result, rsp_result;
   logic              rsp_valid, rsp_err, busy;
   logic              rsp_ready = 1'b0;
   logic [1:0]        rsp_id;

   int cyc = 0, starts = 0, errors = 0, checks = 0, ptr_m = 0, stub_lat = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mm_start) starts <= starts + 1;

   matmul_job_arbiter #(
      .DATA_WIDTH(DW), .M(M), .N(N), .P(P), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b), .mm_start_o(mm_start), .mm_a_o(mm_a),
      .mm_b_o(mm_b), .mm_done_i(mm_done), .mm_result_i(mm_result),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_result_o(rsp_result), .rsp_err_o(rsp_err), .busy_o(busy)
   );

   function automatic logic [RW-1:0] mmul(input logic [AW-1:0] a, input logic [BW-1:0] b);
      logic [RW-1:0] c;
      int s;
      c = '0;
      for (int i = 0; i < M; i++)
         for (int p = 0; p < P; p++) begin
            s = 0;
            for (int n = 0; n < N; n++)
               s += int'(a[(i*N+n)*DW +: DW]) * int'(b[(n*P+p)*DW +: DW]);
            c[(i*P+p)*DW +: DW] = s[DW-1:0];
         end
      return c;
   endfunction

   function automatic logic [AW-1:0] rnd_vec();
      logic [AW-1:0] v;
      for (int k = 0; k < AW/32; k++) v[k*32 +: 32] = $urandom();
      return v;
   endfunction

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int i = 0; i < NR; i++)
         if (v[(ptr+i)%NR]) return (ptr+i)%NR;
      return -1;
   endfunction

   // Stub multiplier: done arrives stub_lat cycles into BUSY; negative = never.
   logic          armed;
   int            cnt;
   logic [RW-1:0] stub_res;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         armed <= 1'b0; cnt <= 0; stub_res <= '0;
      end else if (mm_start) begin
         armed <= (stub_lat >= 0); cnt <= stub_lat; stub_res <= mmul(mm_a, mm_b);
      end else if (armed) begin
         if (cnt == 0) armed <= 1'b0;
         else cnt <= cnt - 1;
      end
   end
   assign mm_done   = (armed && cnt == 0) || done_x;
   assign mm_result = stub_res;

   task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bail(input string tag);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired", tag);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "bench aborted");
   endtask

   task automatic reset_checks();
      chk("rst_req_ready", RW'(req_ready), '0);
      chk("rst_mm_start", RW'(mm_start), '0);
      chk("rst_rsp_valid", RW'(rsp_valid), '0);
      chk("rst_rsp_err", RW'(rsp_err), '0);
      chk("rst_busy", RW'(busy), '0);
      chk("rst_mm_a", RW'(mm_a), '0);
      chk("rst_mm_b", RW'(mm_b), '0);
      chk("rst_rsp_result", rsp_result, '0);
      chk("rst_rsp_id", RW'(rsp_id), '0);
   endtask

   // Called and returns at negedge+1 of a cycle; serves exactly one job.
   task automatic serve(input bit keep, input int delay, input int lat,
                        output int w, output int t_x, output int t_a);
      int k, s0, elat;
      logic [NR-1:0] oh;
      logic [AW-1:0] ea;
      logic [BW-1:0] eb;
      logic [RW-1:0] er;
      logic          eerr;
      #1;
      k = 0;
      while (req_ready == '0) begin
         if (k >= 3000) bail("grant_wait");
         @(negedge clk); #1; k++;
      end
      w = pick(req_valid, ptr_m);
      if (w < 0) bail("grant_without_request");
      oh = '0; oh[w] = 1'b1;
      chk("grant_onehot", RW'(req_ready), RW'(oh));
      ea   = req_a[w*AW +: AW];
      eb   = req_b[w*BW +: BW];
      eerr = (lat < 0);
      er   = eerr ? '0 : mmul(ea, eb);
      elat = eerr ? TO + 2 : lat + 3;
      t_x  = cyc;
      ptr_m = (w + 1) % NR;
      s0 = starts;
      @(negedge clk);
      if (keep) begin
         req_a[w*AW +: AW] = rnd_vec();
         req_b[w*BW +: BW] = rnd_vec();
      end else req_valid[w] = 1'b0;
      #1;
      chk("launch_mm_start", RW'(mm_start), RW'(1));
      chk("launch_mm_a", RW'(mm_a), RW'(ea));
      chk("launch_mm_b", RW'(mm_b), RW'(eb));
      chk("launch_busy", RW'(busy), RW'(1));
      chk("launch_no_grant", RW'(req_ready), '0);
      k = 0;
      while (!rsp_valid) begin
         if (k >= TO + 100) bail("rsp_wait");
         @(negedge clk); #1; k++;
      end
      chk("rsp_latency", RW'(cyc - t_x), RW'(elat));
      chk("rsp_id", RW'(rsp_id), RW'(w));
      chk("rsp_result", rsp_result, er);
      chk("rsp_err", RW'(rsp_err), RW'(eerr));
      chk("start_pulses", RW'(starts - s0), RW'(1));
      for (int d = 0; d < delay; d++) begin
         @(negedge clk); #1;
         chk("bp_valid", RW'(rsp_valid), RW'(1));
         chk("bp_id", RW'(rsp_id), RW'(w));
         chk("bp_result", rsp_result, er);
         chk("bp_err", RW'(rsp_err), RW'(eerr));
         chk("bp_no_grant", RW'(req_ready), '0);
      end
      rsp_ready = 1'b1;
      t_a = cyc;
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      chk("post_acc_valid", RW'(rsp_valid), '0);
      chk("post_acc_busy", RW'(busy), '0);
   endtask

   initial begin
      int w, tx, ta, tx2, ta2, seen;
      logic [AW-1:0] ident;
      logic [BW-1:0] bpat;
      logic [NR-1:0] m;

      repeat (3) @(negedge clk);
      #1 reset_checks();
      @(negedge clk);
      rst = 1'b0;

      // single job: identity times B pattern returns B
      ident = '0;
      for (int i = 0; i < M; i++) ident[(i*N+i)*DW +: DW] = 8'd1;
      for (int n = 0; n < N; n++)
         for (int p = 0; p < P; p++) bpat[(n*P+p)*DW +: DW] = DW'(n*8 + p);
      req_a[2*AW +: AW] = ident;
      req_b[2*BW +: BW] = bpat;
      req_valid = 4'b0100;
      stub_lat = M*N*P;
      serve(1'b0, 0, M*N*P, w, tx, ta);
      chk("single_id", RW'(w), RW'(2));
      chk("single_result_is_B", rsp_result, RW'(bpat));

      // contention from reset
      rst = 1'b1;
      @(negedge clk);
      for (int r = 0; r < NR; r++) begin
         req_a[r*AW +: AW] = rnd_vec();
         req_b[r*BW +: BW] = rnd_vec();
      end
      req_valid = '1;
      rst = 1'b0;
      ptr_m = 0;
      for (int i = 0; i < 5; i++) begin
         stub_lat = $urandom_range(0, 30);
         serve(1'b1, $urandom_range(0, 2), stub_lat, w, tx, ta);
         chk("rr_order", RW'(w), RW'(i % NR));
      end
      req_valid = '0;

      // backpressure, then back-to-back grant
      req_a[1*AW +: AW] = rnd_vec(); req_b[1*BW +: BW] = rnd_vec();
      req_a[3*AW +: AW] = rnd_vec(); req_b[3*BW +: BW] = rnd_vec();
      req_valid = 4'b1010;
      stub_lat = 10;
      serve(1'b0, 5, 10, w, tx, ta);
      chk("bp_first_id", RW'(w), RW'(1));
      serve(1'b0, 0, 10, w, tx2, ta2);
      chk("bp_second_id", RW'(w), RW'(3));
      chk("b2b_gap", RW'(tx2), RW'(ta + 1));

      // timeout, then a stray done while idle
      req_a[0 +: AW] = rnd_vec(); req_b[0 +: BW] = rnd_vec();
      req_valid = 4'b0001;
      stub_lat = -1;
      serve(1'b0, 1, -1, w, tx, ta);
      done_x = 1'b1;
      @(negedge clk);
      done_x = 1'b0;
      #1;
      chk("late_done_busy", RW'(busy), '0);
      chk("late_done_valid", RW'(rsp_valid), '0);
      chk("late_done_start", RW'(mm_start), '0);
      chk("late_done_err_hold", RW'(rsp_err), RW'(1));

      // done in the same BUSY cycle as the timeout
      req_a[2*AW +: AW] = rnd_vec(); req_b[2*BW +: BW] = rnd_vec();
      req_valid = 4'b0100;
      stub_lat = TO - 1;
      serve(1'b0, 0, TO - 1, w, tx, ta);

      // randomized traffic
      for (int j = 0; j < 6; j++) begin
         m = NR'($urandom_range(1, (1 << NR) - 1));
         for (int r = 0; r < NR; r++)
            if (m[r] && !req_valid[r]) begin
               req_a[r*AW +: AW] = rnd_vec();
               req_b[r*BW +: BW] = rnd_vec();
            end
         req_valid = req_valid | m;
         stub_lat = $urandom_range(0, 40);
         serve(1'b0, $urandom_range(0, 3), stub_lat, w, tx, ta);
      end
      req_valid = '0;

      // reset in the middle of BUSY
      req_a[1*AW +: AW] = rnd_vec(); req_b[1*BW +: BW] = rnd_vec();
      req_valid = 4'b0010;
      stub_lat = 300;
      #1 chk("mid_grant", RW'(req_ready), RW'(4'b0010));
      @(negedge clk);
      req_valid = '0;
      #1 chk("mid_start", RW'(mm_start), RW'(1));
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1 reset_checks();
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 0;
      seen = 0;
      for (int c = 0; c < 320; c++) begin
         @(negedge clk); #1;
         if (rsp_valid || busy) seen++;
      end
      chk("mid_no_response", RW'(seen), '0);
      req_a[0 +: AW] = rnd_vec(); req_b[0 +: BW] = rnd_vec();
      req_a[3*AW +: AW] = rnd_vec(); req_b[3*BW +: BW] = rnd_vec();
      req_valid = 4'b1001;
      stub_lat = 5;
      serve(1'b0, 0, 5, w, tx, ta);
      chk("post_rst_id", RW'(w), RW'(0));
      req_valid = '0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
